pc_sequencer: RTL and testbench
===============================

Name: pc_sequencer

Overview:
- Fetch/next-PC controller for the single-cycle MIPS core.
- Owns the PC register and runs a fetch handshake to instruction memory.
- Once the datapath reports completion, selects the next PC from four sources: sequential, branch, jump (word-index shifted left 2) or jump-register.
- Sits between the instruction-memory port and the control unit, and replaces the free-running PC register plus next-PC mux.

Parameters:
- RESET_PC, 32'h0000_0000: PC value loaded on reset; must be word aligned.
- JIDX_W, 26: width of the J-type instruction index field.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- fetch_req  out  1  instruction-memory request valid.
- fetch_addr  out  32  fetch address; always equals pc.
- fetch_ack  in  1  instruction memory has returned the instruction this cycle.
- instr_done  in  1  datapath has finished the current instruction; control inputs below are valid this cycle.
- branch_taken  in  1  conditional branch resolved taken.
- branch_imm  in  16  I-type immediate (word offset).
- jump  in  1  J/JAL.
- jump_index  in  JIDX_W  J-type index field.
- jump_reg  in  1  JR/JALR.
- jr_target  in  32  register-sourced target.
- pc  out  32  current PC.
- pc_plus4  out  32  pc+4, combinational, for the link register.
- redirect  out  1  one-cycle pulse when a non-sequential PC is loaded.
- align_err  out  1  sticky flag: a misaligned jr_target was seen.

Behaviour:
- Reset (async, rst_n low):
  - pc=RESET_PC, state=BOOT.
  - fetch_req=0, redirect=0, align_err=0.
  - Pending-target registers cleared.
- State BOOT: lasts one cycle after reset release, then goes to FETCH.
- State FETCH:
  - fetch_req=1; fetch_addr=pc held stable.
  - On fetch_ack, go to EXEC next cycle and drop fetch_req.
  - Without fetch_ack, stay in FETCH indefinitely.
- State EXEC:
  - fetch_req=0.
  - On instr_done, load pc with next_pc and return to FETCH.
  - instr_done is ignored in any state other than EXEC.
- Latency:
  - instr_done in cycle N gives the new pc and fetch_req=1 in cycle N+1.
  - redirect is asserted in cycle N+1 only.
- Next-PC priority: jump_reg > jump > branch_taken > sequential. Simultaneous assertions are legal and resolved by this order.
- Target arithmetic, all modulo 2^32 (no overflow detection, wrap silently):
  - Sequential: pc+4.
  - Branch: pc+4 + sign_extend(branch_imm) shifted left 2.
  - Jump: {pc_plus4[31:28], jump_index, 2'b00}.
  - Jump-register: {jr_target[31:2], 2'b00}. If jr_target[1:0] is non-zero, set align_err; it stays set until reset.
- redirect=1 when the selected source is not sequential, even if the target happens to equal pc+4.
- Reset mid-fetch or mid-execute: immediate return to BOOT. Any outstanding request is abandoned; memory must tolerate fetch_req dropping without ack.

Optional Feature:
- Macro: DELAY_SLOT_EN.
- Defined (MIPS branch delay slot):
  - A taken control transfer at instr_done loads pc+4 and stores the target in a pending register.
  - The next instr_done (the delay-slot instruction) loads the pending target and pulses redirect; that instruction's own control inputs are ignored.
  - Jump base stays the delay-slot address (pc+4 of the transfer).
  - Reset clears the pending target.
- Undefined: no pending register; the transfer takes effect immediately, as described in Behaviour.

Decomposition:
- Shared package mips_pkg holds:
  - state encoding typedef (BOOT, FETCH, EXEC);
  - next-PC source enum (SEQ, BR, J, JR);
  - constants PC_W=32 and WORD_SHIFT=2.
- One natural sub-module: pc_target_calc, purely combinational. It computes the branch, jump and aligned jump-register targets plus the priority select; the FSM and registers stay in pc_sequencer.

Test Plan:
- Reset then ack every fetch:
  - pc=0, BOOT for 1 cycle, then fetch_req=1 with fetch_addr=0.
  - After ack and instr_done with no control inputs, pc=4.
- Hold fetch_ack low for 5 cycles: fetch_req stays 1 and fetch_addr stays constant; no pc change.
- Branch at pc=0x100, branch_imm=16'hFFFE:
  - pc becomes 0x0FC and redirect pulses for exactly one cycle.
  - With DELAY_SLOT_EN: pc goes 0x104 then 0x0FC.
- Jump at pc=0xF000_0010, jump_index=26'h000_0040: pc becomes 0xF000_0100.
- jump_reg=1, jump=1 and branch_taken=1 together, jr_target=0x0000_2003: pc=0x0000_2000, align_err=1 and stays set.
- Assert rst_n low during EXEC at pc=0x40: pc=RESET_PC immediately, fetch_req=0, align_err cleared.

Source files
------------

// File: rtl/mips_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mips_pkg
// Description : Types and constants shared by the PC sequencer and its
//               next-PC target calculator.
// Revision    : 1.0 - initial release
// ============================================================================
package mips_pkg;

  localparam int PC_W       = 32;
  localparam int WORD_SHIFT = 2;

  // Fetch/execute handshake states
  typedef enum logic [1:0] {
    BOOT  = 2'd0,
    FETCH = 2'd1,
    EXEC  = 2'd2
  } seq_state_t;

  // Next-PC source, listed from lowest to highest priority
  typedef enum logic [1:0] {
    SEQ = 2'd0,
    BR  = 2'd1,
    J   = 2'd2,
    JR  = 2'd3
  } pc_src_t;

endpackage
`default_nettype wire

// File: rtl/pc_target_calc.sv
`default_nettype none
// ============================================================================
// Module      : pc_target_calc
// Description : Combinational next-PC target generation and priority select
//               (jump_reg > jump > branch_taken > sequential).
// Revision    : 1.0 - initial release
// ============================================================================
module pc_target_calc
  import mips_pkg::*;
#(
  parameter int JIDX_W = 26
) (
  input  logic [PC_W-1:0]   pc_plus4,
  input  logic              branch_taken,
  input  logic [15:0]       branch_imm,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              jump_reg,
  input  logic [PC_W-1:0]   jr_target,
  output logic [PC_W-1:0]   target,
  output pc_src_t           src,
  output logic              jr_misaligned
);

  logic [PC_W-1:0] w_br_off;
  logic [PC_W-1:0] w_br_target;
  logic [PC_W-1:0] w_j_target;
  logic [PC_W-1:0] w_jr_target;

  // Word offset sign-extended and scaled to a byte offset
  assign w_br_off    = {{(PC_W-16-WORD_SHIFT){branch_imm[15]}}, branch_imm, {WORD_SHIFT{1'b0}}};
  assign w_br_target = pc_plus4 + w_br_off;

  // Region bits come from the delay-slot address (pc+4), not the jump itself
  assign w_j_target  = {pc_plus4[PC_W-1:JIDX_W+WORD_SHIFT], jump_index, {WORD_SHIFT{1'b0}}};

  // Register targets are forced to word alignment; the low bits only flag an error
  assign w_jr_target   = {jr_target[PC_W-1:WORD_SHIFT], {WORD_SHIFT{1'b0}}};
  assign jr_misaligned = |jr_target[WORD_SHIFT-1:0];

  // Priority select of the next-PC source
  always_comb begin
    target = pc_plus4;
    src    = SEQ;
    if (jump_reg) begin
      target = w_jr_target;
      src    = JR;
    end else if (jump) begin
      target = w_j_target;
      src    = J;
    end else if (branch_taken) begin
      target = w_br_target;
      src    = BR;
    end
  end

endmodule
`default_nettype wire

// File: rtl/pc_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : pc_sequencer
// Description : PC register, instruction-fetch handshake and next-PC update
//               for the single-cycle MIPS core.
//               Optional macro DELAY_SLOT_EN: MIPS branch delay slot, the
//               taken target is held pending for one instruction.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_sequencer
  import mips_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          JIDX_W   = 26
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic              fetch_req,
  output logic [31:0]       fetch_addr,
  input  logic              fetch_ack,
  input  logic              instr_done,
  input  logic              branch_taken,
  input  logic [15:0]       branch_imm,
  input  logic              jump,
  input  logic [JIDX_W-1:0] jump_index,
  input  logic              jump_reg,
  input  logic [31:0]       jr_target,
  output logic [31:0]       pc,
  output logic [31:0]       pc_plus4,
  output logic              redirect,
  output logic              align_err
);

  seq_state_t      r_state;
  logic [PC_W-1:0] r_pc;
  logic            r_fetch_req;
  logic            r_redirect;
  logic            r_align_err;

  logic [PC_W-1:0] w_pc_plus4;
  logic [PC_W-1:0] w_target;
  pc_src_t         w_src;
  logic            w_jr_misaligned;

  assign w_pc_plus4 = r_pc + 32'd4;

  pc_target_calc #(
    .JIDX_W (JIDX_W)
  ) u_target_calc (
    .pc_plus4      (w_pc_plus4),
    .branch_taken  (branch_taken),
    .branch_imm    (branch_imm),
    .jump          (jump),
    .jump_index    (jump_index),
    .jump_reg      (jump_reg),
    .jr_target     (jr_target),
    .target        (w_target),
    .src           (w_src),
    .jr_misaligned (w_jr_misaligned)
  );

`ifdef DELAY_SLOT_EN
  logic            r_pend_valid;
  logic [PC_W-1:0] r_pend_target;

  // Fetch FSM, PC update and delayed-transfer bookkeeping
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= BOOT;
      r_pc          <= RESET_PC;
      r_fetch_req   <= 1'b0;
      r_redirect    <= 1'b0;
      r_align_err   <= 1'b0;
      r_pend_valid  <= 1'b0;
      r_pend_target <= '0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state     <= FETCH;
          r_fetch_req <= 1'b1;
        end
        FETCH: begin
          if (fetch_ack) begin
            r_state     <= EXEC;
            r_fetch_req <= 1'b0;
          end
        end
        EXEC: begin
          if (instr_done) begin
            r_state     <= FETCH;
            r_fetch_req <= 1'b1;
            if (r_pend_valid) begin
              // Delay-slot instruction retires: its own control inputs are ignored
              r_pc         <= r_pend_target;
              r_redirect   <= 1'b1;
              r_pend_valid <= 1'b0;
            end else begin
              r_pc <= w_pc_plus4;
              if (w_src != SEQ) begin
                r_pend_target <= w_target;
                r_pend_valid  <= 1'b1;
              end
              if (w_src == JR && w_jr_misaligned) begin
                r_align_err <= 1'b1;
              end
            end
          end
        end
        default: begin
          r_state     <= BOOT;
          r_fetch_req <= 1'b0;
        end
      endcase
    end
  end
`else
  // Fetch FSM and immediate PC update on instruction completion
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= BOOT;
      r_pc        <= RESET_PC;
      r_fetch_req <= 1'b0;
      r_redirect  <= 1'b0;
      r_align_err <= 1'b0;
    end else begin
      r_redirect <= 1'b0;
      case (r_state)
        BOOT: begin
          r_state     <= FETCH;
          r_fetch_req <= 1'b1;
        end
        FETCH: begin
          if (fetch_ack) begin
            r_state     <= EXEC;
            r_fetch_req <= 1'b0;
          end
        end
        EXEC: begin
          if (instr_done) begin
            r_state     <= FETCH;
            r_fetch_req <= 1'b1;
            r_pc        <= w_target;
            r_redirect  <= (w_src != SEQ);
            if (w_src == JR && w_jr_misaligned) begin
              r_align_err <= 1'b1;
            end
          end
        end
        default: begin
          r_state     <= BOOT;
          r_fetch_req <= 1'b0;
        end
      endcase
    end
  end
`endif

  assign pc         = r_pc;
  assign pc_plus4   = w_pc_plus4;
  assign fetch_addr = r_pc;
  assign fetch_req  = r_fetch_req;
  assign redirect   = r_redirect;
  assign align_err  = r_align_err;

endmodule
`default_nettype wire

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pc_sequencer
// Description : Self-checking bench for pc_sequencer with a reference model
//               of the next-PC rules (honours DELAY_SLOT_EN when defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        fetch_req;
  logic [31:0] fetch_addr;
  logic        fetch_ack = 1'b0;
  logic        instr_done = 1'b0;
  logic        branch_taken = 1'b0;
  logic [15:0] branch_imm = '0;
  logic        jump = 1'b0;
  logic [25:0] jump_index = '0;
  logic        jump_reg = 1'b0;
  logic [31:0] jr_target = '0;
  logic [31:0] pc;
  logic [31:0] pc_plus4;
  logic        redirect;
  logic        align_err;

  int checks = 0;
  int errors = 0;

  // Reference model state
  logic [31:0] m_pc;
  logic        m_align;
  logic        m_pend;
  logic [31:0] m_pend_tgt;

  pc_sequencer #(
    .RESET_PC (32'h0000_0000),
    .JIDX_W   (26)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .fetch_req    (fetch_req),
    .fetch_addr   (fetch_addr),
    .fetch_ack    (fetch_ack),
    .instr_done   (instr_done),
    .branch_taken (branch_taken),
    .branch_imm   (branch_imm),
    .jump         (jump),
    .jump_index   (jump_index),
    .jump_reg     (jump_reg),
    .jr_target    (jr_target),
    .pc           (pc),
    .pc_plus4     (pc_plus4),
    .redirect     (redirect),
    .align_err    (align_err)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_pc = 32'h0; m_align = 1'b0; m_pend = 1'b0; m_pend_tgt = 32'h0;
  endtask

  // Architectural effect of one retired instruction
  task automatic model_exec(input logic br, input logic [15:0] imm, input logic j,
                            input logic [25:0] idx, input logic jr, input logic [31:0] tgt,
                            output logic exp_red);
    logic [31:0] seq, dest;
    int off;
    seq = m_pc + 32'd4;
    off = int'($signed(imm)) * 4;
    if (jr)      dest = tgt - (tgt % 4);
    else if (j)  dest = (seq & 32'hF000_0000) + idx * 4;
    else if (br) dest = seq + 32'(off);
    else         dest = seq;
`ifdef DELAY_SLOT_EN
    if (m_pend) begin
      m_pc = m_pend_tgt; m_pend = 1'b0; exp_red = 1'b1;
    end else begin
      if (jr && (tgt % 4) != 0) m_align = 1'b1;
      if (jr || j || br) begin m_pend = 1'b1; m_pend_tgt = dest; end
      m_pc = seq; exp_red = 1'b0;
    end
`else
    if (jr && (tgt % 4) != 0) m_align = 1'b1;
    m_pc = dest;
    exp_red = jr || j || br;
`endif
  endtask

  // Fetch handshake plus one instruction retirement; entered and left in FETCH at posedge+1
  task automatic run_instr(input logic br, input logic [15:0] imm, input logic j,
                           input logic [25:0] idx, input logic jr, input logic [31:0] tgt,
                           input int ack_wait,
                           output logic [31:0] o_pc, output logic o_red, output logic o_red2,
                           output logic o_req, output logic o_align, output logic o_timeout);
    int n;
    n = 0;
    o_timeout = 1'b0;
    while (fetch_req !== 1'b1 && n < 20) begin @(posedge clk); #1; n++; end
    if (n >= 20) o_timeout = 1'b1;
    repeat (ack_wait) begin @(posedge clk); #1; end
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    branch_taken = br; branch_imm = imm; jump = j; jump_index = idx;
    jump_reg = jr; jr_target = tgt; instr_done = 1'b1;
    @(posedge clk); #1;
    o_pc = pc; o_red = redirect; o_req = fetch_req; o_align = align_err;
    instr_done = 1'b0; branch_taken = 1'b0; jump = 1'b0; jump_reg = 1'b0;
    @(posedge clk); #1;
    o_red2 = redirect;
  endtask

  task automatic set_pc(input logic [31:0] target);
    logic [31:0] p; logic r, r2, q, a, t, er;
    model_exec(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, target, er);
    run_instr(1'b0, 16'h0, 1'b0, 26'h0, 1'b1, target, 0, p, r, r2, q, a, t);
`ifdef DELAY_SLOT_EN
    model_exec(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, er);
    run_instr(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 0, p, r, r2, q, a, t);
`endif
    checks++;
    if (p !== m_pc || t) begin
      errors++;
      $display("FAIL set_pc: pc=%h timeout=%0b expected pc=%h", p, t, m_pc);
    end
  endtask

  task automatic test_reset();
    logic [31:0] p; logic r, r2, q, a, t, er;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (pc !== 32'h0 || fetch_req !== 1'b0 || redirect !== 1'b0 || align_err !== 1'b0) begin
      errors++;
      $display("FAIL reset_state: pc=%h req=%b red=%b aerr=%b expected 0/0/0/0", pc, fetch_req, redirect, align_err);
    end
    @(negedge clk); rst_n = 1'b1;
    #1;
    checks++;
    if (fetch_req !== 1'b0) begin
      errors++; $display("FAIL boot_no_req: fetch_req=%b expected 0", fetch_req);
    end
    @(posedge clk); #1;
    checks++;
    if (fetch_req !== 1'b1 || fetch_addr !== 32'h0) begin
      errors++; $display("FAIL first_fetch: req=%b addr=%h expected 1/00000000", fetch_req, fetch_addr);
    end
    model_reset();
    model_exec(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, er);
    run_instr(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 0, p, r, r2, q, a, t);
    checks++;
    if (p !== 32'h4 || r !== 1'b0 || q !== 1'b1 || t) begin
      errors++; $display("FAIL seq_step: pc=%h red=%b req=%b expected 00000004/0/1", p, r, q);
    end
  endtask

  task automatic test_fetch_stall();
    logic [31:0] p0, p; logic r, r2, q, a, t, er;
    p0 = pc;
    // control inputs outside EXEC must have no effect
    instr_done = 1'b1; jump = 1'b1; jump_index = 26'h3FF_FFFF;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checks++;
      if (fetch_req !== 1'b1 || fetch_addr !== p0 || pc !== p0) begin
        errors++;
        $display("FAIL fetch_stall cyc%0d: req=%b addr=%h pc=%h expected 1/%h/%h", i, fetch_req, fetch_addr, pc, p0, p0);
      end
    end
    instr_done = 1'b0; jump = 1'b0;
    model_exec(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, er);
    run_instr(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 2, p, r, r2, q, a, t);
    checks++;
    if (p !== m_pc || p !== p0 + 32'd4 || t) begin
      errors++; $display("FAIL after_stall: pc=%h expected %h", p, p0 + 32'd4);
    end
  endtask

  task automatic test_branch();
    logic [31:0] p; logic r, r2, q, a, t, er;
    set_pc(32'h0000_0100);
    model_exec(1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0, er);
    run_instr(1'b1, 16'hFFFE, 1'b0, 26'h0, 1'b0, 32'h0, 1, p, r, r2, q, a, t);
`ifdef DELAY_SLOT_EN
    checks++;
    if (p !== 32'h0000_0104 || r !== 1'b0) begin
      errors++; $display("FAIL branch_slot: pc=%h red=%b expected 00000104/0", p, r);
    end
    model_exec(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, er);
    run_instr(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 0, p, r, r2, q, a, t);
`endif
    checks++;
    if (p !== 32'h0000_00FC || r !== 1'b1 || r2 !== 1'b0 || t) begin
      errors++; $display("FAIL branch_back: pc=%h red=%b red_next=%b expected 000000fc/1/0", p, r, r2);
    end
  endtask

  task automatic test_jump();
    logic [31:0] p; logic r, r2, q, a, t, er;
    set_pc(32'hF000_0010);
    model_exec(1'b0, 16'h0, 1'b1, 26'h000_0040, 1'b0, 32'h0, er);
    run_instr(1'b0, 16'h0, 1'b1, 26'h000_0040, 1'b0, 32'h0, 0, p, r, r2, q, a, t);
`ifdef DELAY_SLOT_EN
    model_exec(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, er);
    run_instr(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 0, p, r, r2, q, a, t);
`endif
    checks++;
    if (p !== 32'hF000_0100 || r !== 1'b1 || t) begin
      errors++; $display("FAIL jump_region: pc=%h red=%b expected f0000100/1", p, r);
    end
  endtask

  task automatic test_jr_priority();
    logic [31:0] p; logic r, r2, q, a, t, er;
    model_exec(1'b1, 16'h0010, 1'b1, 26'h000_0123, 1'b1, 32'h0000_2003, er);
    run_instr(1'b1, 16'h0010, 1'b1, 26'h000_0123, 1'b1, 32'h0000_2003, 0, p, r, r2, q, a, t);
`ifdef DELAY_SLOT_EN
    model_exec(1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0, er);
    run_instr(1'b1, 16'h0010, 1'b0, 26'h0, 1'b0, 32'h0, 0, p, r, r2, q, a, t);
`endif
    checks++;
    if (p !== 32'h0000_2000 || a !== 1'b1 || r !== 1'b1 || t) begin
      errors++; $display("FAIL jr_priority: pc=%h aerr=%b red=%b expected 00002000/1/1", p, a, r);
    end
    model_exec(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, er);
    run_instr(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 0, p, r, r2, q, a, t);
    checks++;
    if (a !== 1'b1 || p !== 32'h0000_2004) begin
      errors++; $display("FAIL align_sticky: aerr=%b pc=%h expected 1/00002004", a, p);
    end
  endtask

  task automatic test_reset_mid_exec();
    logic [31:0] p; logic r, r2, q, a, t, er;
    set_pc(32'h0000_0040);
    fetch_ack = 1'b1;
    @(posedge clk); #1;
    fetch_ack = 1'b0;
    checks++;
    if (pc !== 32'h40 || fetch_req !== 1'b0 || align_err !== 1'b1) begin
      errors++; $display("FAIL exec_entry: pc=%h req=%b aerr=%b expected 00000040/0/1", pc, fetch_req, align_err);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (pc !== 32'h0 || fetch_req !== 1'b0 || align_err !== 1'b0 || redirect !== 1'b0) begin
      errors++; $display("FAIL async_reset: pc=%h req=%b aerr=%b red=%b expected 0/0/0/0", pc, fetch_req, align_err, redirect);
    end
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    model_reset();
    model_exec(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, er);
    run_instr(1'b0, 16'h0, 1'b0, 26'h0, 1'b0, 32'h0, 0, p, r, r2, q, a, t);
    checks++;
    if (p !== 32'h4 || a !== 1'b0 || t) begin
      errors++; $display("FAIL post_reset_step: pc=%h aerr=%b expected 00000004/0", p, a);
    end
  endtask

  task automatic test_random();
    logic [31:0] p, tgt; logic r, r2, q, a, t, er, br, j, jr;
    logic [15:0] imm; logic [25:0] idx;
    for (int i = 0; i < 60; i++) begin
      br  = ($urandom_range(0, 2) == 0);
      j   = ($urandom_range(0, 4) == 0);
      jr  = ($urandom_range(0, 5) == 0);
      imm = 16'($urandom);
      idx = 26'($urandom);
      tgt = $urandom;
      if ($urandom_range(0, 1) == 0) tgt[1:0] = 2'b00;
      model_exec(br, imm, j, idx, jr, tgt, er);
      run_instr(br, imm, j, idx, jr, tgt, $urandom_range(0, 3), p, r, r2, q, a, t);
      checks++;
      if (p !== m_pc || r !== er || r2 !== 1'b0 || a !== m_align || q !== 1'b1 || t ||
          fetch_addr !== m_pc || pc_plus4 !== m_pc + 32'd4) begin
        errors++;
        $display("FAIL random[%0d]: pc=%h red=%b red_next=%b aerr=%b req=%b expected pc=%h red=%b aerr=%b req=1",
                 i, p, r, r2, a, q, m_pc, er, m_align);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fetch_stall();
    test_branch();
    test_jump();
    test_jr_priority();
    test_reset_mid_exec();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
